pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter CTRL_W, default 16, SHALL set the width of the control field (RegWrite, MemWrite, ALUOp and similar bits) in bits.
REQ-003 Parameter DATA_W, default 192, SHALL set the width of the datapath payload (operands, immediate, PC+4, register numbers) in bits.
REQ-004 Parameter SKID, default 1, SHALL select the buffering mode: 1 = two-entry skid with registered in_ready; 0 = single entry with combinational in_ready.
REQ-005 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port in_valid, input, 1 bit, SHALL indicate that the upstream stage presents an instruction.
REQ-008 Port in_ready, output, 1 bit, SHALL indicate that the stage accepts an instruction this cycle.
REQ-009 Port in_ctrl, input, CTRL_W bits, SHALL carry the upstream control field.
REQ-010 Port in_data, input, DATA_W bits, SHALL carry the upstream payload.
REQ-011 Port stall, input, 1 bit, SHALL be a hazard-unit hold: while high, nothing leaves the stage.
REQ-012 Port flush, input, 1 bit, SHALL be a branch/hazard kill that discards every held instruction.
REQ-013 Port out_valid, output, 1 bit, SHALL indicate that the held instruction is valid.
REQ-014 Port out_ready, input, 1 bit, SHALL indicate that the downstream stage can take the instruction.
REQ-015 Port out_ctrl, output, CTRL_W bits, SHALL be the registered control field.
REQ-016 Port out_data, output, DATA_W bits, SHALL be the registered payload.
REQ-017 Port occupancy, output, 2 bits, SHALL report the number of held entries (0 to 2).

Function
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are high and stall is low.
REQ-019 Latency SHALL be one cycle: an instruction accepted at edge N is presented on out_* after edge N, with no combinational in->out path.
REQ-020 When SKID=1, the stage SHALL be a state machine with states EMPTY, ONE and TWO; EMPTY goes to ONE on an input transfer; ONE goes to EMPTY on an output transfer without an input transfer, and to TWO on an input transfer without an output transfer; TWO goes to ONE on an output transfer; any other combination holds the current state.
REQ-021 When SKID=1, in_ready SHALL be a register equal to (state != TWO), asserted 1 after reset.
REQ-022 In state TWO the older entry SHALL drive out_*, and the skid entry SHALL move into the main register on the output transfer.
REQ-023 When SKID=0, in_ready SHALL equal !out_valid | (out_ready & !stall), the depth SHALL be 1, and occupancy SHALL never exceed 1.
REQ-024 Ordering SHALL be strictly FIFO; no instruction is ever dropped or duplicated without a flush.
REQ-025 out_ctrl SHALL be all zeros whenever out_valid is 0 (bubble = NOP controls); out_data is don't-care while out_valid is 0.
REQ-026 On flush at edge N, after edge N the stage SHALL be empty with out_valid=0, out_ctrl=0, occupancy=0 and the state EMPTY, and an input transfer in the same cycle SHALL also be discarded.
REQ-027 flush SHALL have priority over stall, and stall SHALL have priority over out_ready.
REQ-028 While stall is high, out_* SHALL hold stable, and input transfers SHALL continue only while in_ready is high.
REQ-029 Simultaneous input and output transfers in ONE SHALL keep the state in ONE and replace the main register with the new entry.

Reset
REQ-030 On rst high at a rising edge, the stage SHALL set out_valid=0, out_ctrl=0, out_data=0, occupancy=0, state EMPTY, and in_ready=1 (SKID=1).
REQ-031 rst SHALL override flush, stall and any transfer in the same cycle, and mid-operation resets SHALL discard all entries.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default CTRL_W and DATA_W constants.
REQ-033 The skid entry SHALL be one sub-module, pipe_skid_entry: a load-enabled register holding {valid, ctrl, data}, instantiated only when SKID=1.

Verification
REQ-034 Reset SHALL be verified: rst for 2 cycles -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
REQ-035 Streaming SHALL be verified: 8 back-to-back instructions with ctrl 0x0001..0x0008 and out_ready=1 -> each appears 1 cycle later, in order, with no gaps.
REQ-036 Backpressure SHALL be verified: out_ready=0 with 3 offered instructions -> occupancy=2 and in_ready=0 after the 2nd; the 3rd is held upstream, and all 3 exit in order when out_ready=1.
REQ-037 Stall SHALL be verified: stall=1 for 4 cycles with out_ready=1 and ctrl 0x00A5 held -> out_ctrl stays 0x00A5 and no output transfer occurs.
REQ-038 Flush SHALL be verified: flush with occupancy=2 and simultaneous in_valid=1 -> next cycle out_valid=0, out_ctrl=0x0000, occupancy=0.
REQ-039 SKID=0 SHALL be verified: stall=0 and out_ready=1 -> in_ready=1 combinationally; out_ready=0 with 1 entry held -> in_ready=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
// Holds the occupancy state encoding and the default field widths.
package pipe_pkg;

   // Default width of the control field (RegWrite, MemWrite, ALUOp, ...).
   localparam int unsigned PIPE_CTRL_W = 16;
   // Default width of the datapath payload (operands, immediate, PC+4, regs).
   localparam int unsigned PIPE_DATA_W = 192;

   // Encoding equals the number of held entries, so occupancy is a cast.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_entry.sv
// Skid entry of the pipeline stage: a load-enabled register of
// {valid, ctrl, data}. Cleared by synchronous reset.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   load            - capture d_* on the rising edge
//   d_valid/ctrl/data - next entry contents
//   q_valid/ctrl/data - held entry contents
module pipe_skid_entry #(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned DATA_W = 192
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              d_valid,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              q_valid,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data
);

   // Entry register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_ctrl  <= '0;
         q_data  <= '0;
      end else if (load) begin
         q_valid <= d_valid;
         q_ctrl  <= d_ctrl;
         q_data  <= d_data;
      end
   end

endmodule : pipe_skid_entry

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard stall and
// flush. SKID=1 gives a two-entry skid buffer with registered in_ready;
// SKID=0 gives a single entry with combinational in_ready.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - upstream handshake
//   in_ctrl/in_data      - upstream control field and payload
//   stall                - hold: nothing leaves the stage while high
//   flush                - discard every held entry (and same-cycle input)
//   out_valid/out_ready  - downstream handshake
//   out_ctrl/out_data    - registered control field (0 on bubble) and payload
//   occupancy            - number of held entries (0..2)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = PIPE_CTRL_W,
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   state_e            state_q;
   state_e            state_d;
   logic              valid_d;
   logic [CTRL_W-1:0] ctrl_d;
   logic [DATA_W-1:0] data_d;
   logic              in_ready_d;

   logic              skid_load;
   logic              skid_d_valid;
   logic [CTRL_W-1:0] skid_d_ctrl;
   logic [DATA_W-1:0] skid_d_data;
   logic              skid_q_valid;
   logic [CTRL_W-1:0] skid_q_ctrl;
   logic [DATA_W-1:0] skid_q_data;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready & ~stall;

   // Next-state and next-entry logic. With SKID=0, in_ready in ONE equals
   // out_xfer, so TWO is unreachable and the same FSM gives depth 1.
   always_comb begin
      state_d      = state_q;
      valid_d      = out_valid;
      ctrl_d       = out_ctrl;
      data_d       = out_data;
      skid_load    = 1'b0;
      skid_d_valid = 1'b0;
      skid_d_ctrl  = '0;
      skid_d_data  = '0;

      unique case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               valid_d = 1'b1;
               ctrl_d  = in_ctrl;
               data_d  = in_data;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               valid_d = 1'b1;
               ctrl_d  = in_ctrl;
               data_d  = in_data;
            end else if (in_xfer) begin
               // Main entry is stuck downstream; park the newcomer.
               state_d      = TWO;
               skid_load    = 1'b1;
               skid_d_valid = 1'b1;
               skid_d_ctrl  = in_ctrl;
               skid_d_data  = in_data;
            end else if (out_xfer) begin
               state_d = EMPTY;
               valid_d = 1'b0;
               ctrl_d  = '0;
            end
         end
         TWO: begin
            if (out_xfer) begin
               // Older entry leaves; skid entry moves up to the main register.
               state_d   = ONE;
               valid_d   = skid_q_valid;
               ctrl_d    = skid_q_ctrl;
               data_d    = skid_q_data;
               skid_load = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
      endcase

      // Flush wins over stall and any transfer, including same-cycle input.
      if (flush) begin
         state_d      = EMPTY;
         valid_d      = 1'b0;
         ctrl_d       = '0;
         skid_load    = 1'b1;
         skid_d_valid = 1'b0;
         skid_d_ctrl  = '0;
         skid_d_data  = '0;
      end

      in_ready_d = (state_d != TWO);
   end

   // State and main output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= EMPTY;
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
         occupancy <= 2'd0;
      end else begin
         state_q   <= state_d;
         out_valid <= valid_d;
         out_ctrl  <= ctrl_d;
         out_data  <= data_d;
         occupancy <= 2'(state_d);
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic in_ready_q;

         pipe_skid_entry #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
         ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load    (skid_load),
            .d_valid (skid_d_valid),
            .d_ctrl  (skid_d_ctrl),
            .d_data  (skid_d_data),
            .q_valid (skid_q_valid),
            .q_ctrl  (skid_q_ctrl),
            .q_data  (skid_q_data)
         );

         // Registered ready: low only while both entries are occupied.
         always_ff @(posedge clk) begin
            if (rst) begin
               in_ready_q <= 1'b1;
            end else begin
               in_ready_q <= in_ready_d;
            end
         end

         assign in_ready = in_ready_q;
      end else begin : g_single
         logic unused_skid;

         assign skid_q_valid = 1'b0;
         assign skid_q_ctrl  = '0;
         assign skid_q_data  = '0;
         assign unused_skid  = ^{skid_load, skid_d_valid, skid_d_ctrl,
                                 skid_d_data, in_ready_d};

         // Accept when empty or when the held entry leaves this cycle.
         assign in_ready = ~out_valid | (out_ready & ~stall);
      end
   endgenerate

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1 instance checked by a
// decoupled monitor plus directed checks, SKID=0 instance by direct checks.
module tb_pipe_stage_reg;

   localparam int unsigned CW = 16;
   localparam int unsigned DW = 192;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // SKID=1 instance signals
   logic          rst, in_valid, in_ready, stall, flush, out_valid, out_ready;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;

   // SKID=0 instance signals
   logic          z_rst, z_in_valid, z_in_ready, z_stall, z_flush;
   logic          z_out_valid, z_out_ready;
   logic [CW-1:0] z_in_ctrl, z_out_ctrl;
   logic [DW-1:0] z_in_data, z_out_data;
   logic [1:0]    z_occupancy;

   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;
   exp_t sb[$];

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .occupancy(occupancy)
   );

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
      .clk(clk), .rst(z_rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
      .in_ctrl(z_in_ctrl), .in_data(z_in_data), .stall(z_stall), .flush(z_flush),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl),
      .out_data(z_out_data), .occupancy(z_occupancy)
   );

   // Payload derived from the control tag so each instruction is distinct.
   function automatic logic [DW-1:0] pat(input logic [CW-1:0] c);
      return DW'({12{c ^ 16'h5A00}});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [CW-1:0] c);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = pat(c);
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (!out_valid) chk("bubble_ctrl", 32'(out_ctrl), 32'h0);
         if (out_valid && out_ready && !stall) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow actual=%0h expected=none", out_ctrl);
            end else begin
               exp_t e;
               e = sb.pop_front();
               pops++;
               chk("sb_ctrl", 32'(out_ctrl), 32'(e.c));
               checks++;
               if (out_data !== e.d) begin
                  failures++;
                  $display("FAIL sb_data actual=%h expected=%h", out_data, e.d);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back('{c: in_ctrl, d: pat(in_ctrl)});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int p0;
      logic [DW-1:0] zd;

      rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
      stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
      z_rst = 1'b1; z_in_valid = 1'b0; z_in_ctrl = '0; z_in_data = '0;
      z_stall = 1'b0; z_flush = 1'b0; z_out_ready = 1'b0;

      // Reset for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_ctrl",  32'(out_ctrl),  32'h0);
      chk("rst_out_data",  out_data[31:0], 32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h1);
      chk("rst_occupancy", 32'(occupancy), 32'h0);
      chk("z_rst_in_ready", 32'(z_in_ready), 32'h1);
      rst = 1'b0; z_rst = 1'b0;

      // Streaming: 8 back-to-back, each visible one cycle later, no gaps
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(CW'(i));
         @(posedge clk); #1;
         chk("stream_valid", 32'(out_valid), 32'h1);
         chk("stream_ctrl",  32'(out_ctrl),  32'(i));
         chk("stream_ready", 32'(in_ready),  32'h1);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stream_drain_valid", 32'(out_valid), 32'h0);
      chk("stream_drain_occ",   32'(occupancy), 32'h0);

      // Backpressure: two fill the stage, third held upstream
      out_ready = 1'b0;
      send(16'h0011);
      @(posedge clk); #1;
      chk("bp_occ1",   32'(occupancy), 32'h1);
      chk("bp_ctrl1",  32'(out_ctrl),  32'h11);
      chk("bp_ready1", 32'(in_ready),  32'h1);
      send(16'h0012);
      @(posedge clk); #1;
      chk("bp_occ2",   32'(occupancy), 32'h2);
      chk("bp_ready2", 32'(in_ready),  32'h0);
      chk("bp_ctrl2",  32'(out_ctrl),  32'h11);
      send(16'h0013);
      @(posedge clk); #1;
      chk("bp_hold_occ",   32'(occupancy), 32'h2);
      chk("bp_hold_ready", 32'(in_ready),  32'h0);
      chk("bp_hold_ctrl",  32'(out_ctrl),  32'h11);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_drain_b",     32'(out_ctrl),  32'h12);
      chk("bp_drain_occ",   32'(occupancy), 32'h1);
      chk("bp_drain_ready", 32'(in_ready),  32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_drain_c", 32'(out_ctrl), 32'h13);
      @(posedge clk); #1;
      chk("bp_empty_valid", 32'(out_valid), 32'h0);
      chk("bp_sb_empty",    32'(sb.size()), 32'h0);

      // Stall holds the output for 4 cycles
      send(16'h00A5);
      @(posedge clk); #1;
      in_valid = 1'b0;
      stall = 1'b1;
      chk("stall_load", 32'(out_ctrl), 32'hA5);
      p0 = pops;
      repeat (4) begin
         @(posedge clk); #1;
         chk("stall_ctrl",  32'(out_ctrl),  32'hA5);
         chk("stall_valid", 32'(out_valid), 32'h1);
      end
      chk("stall_no_xfer", 32'(pops), 32'(p0));
      stall = 1'b0;
      @(posedge clk); #1;
      chk("stall_release_valid", 32'(out_valid), 32'h0);
      chk("stall_release_pop",   32'(pops), 32'(p0 + 1));

      // Flush with two held entries and in_valid high
      out_ready = 1'b0;
      send(16'h0021);
      @(posedge clk); #1;
      send(16'h0022);
      @(posedge clk); #1;
      chk("flush_pre_occ", 32'(occupancy), 32'h2);
      send(16'h0023);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_ctrl",  32'(out_ctrl),  32'h0);
      chk("flush_occ",   32'(occupancy), 32'h0);
      chk("flush_ready", 32'(in_ready),  32'h1);

      // Flush beats stall and discards an accepted same-cycle input
      send(16'h0031);
      @(posedge clk); #1;
      send(16'h0032);
      flush = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      chk("flush_in_valid", 32'(out_valid), 32'h0);
      chk("flush_in_occ",   32'(occupancy), 32'h0);

      // Mid-operation reset discards both entries
      send(16'h0041);
      @(posedge clk); #1;
      send(16'h0042);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_valid", 32'(out_valid), 32'h0);
      chk("mrst_occ",   32'(occupancy), 32'h0);
      chk("mrst_ready", 32'(in_ready),  32'h1);
      chk("mrst_data",  out_data[31:0], 32'h0);
      out_ready = 1'b1;
      send(16'h0051);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mrst_fresh_ctrl", 32'(out_ctrl), 32'h51);
      @(posedge clk); #1;
      chk("mrst_fresh_empty", 32'(occupancy), 32'h0);

      // SKID=0: combinational ready, depth 1
      z_out_ready = 1'b1; z_stall = 1'b0;
      #1;
      chk("z_ready_empty", 32'(z_in_ready), 32'h1);
      z_out_ready = 1'b0;
      z_in_valid = 1'b1; z_in_ctrl = 16'h0061; z_in_data = pat(16'h0061);
      @(posedge clk); #1;
      z_in_valid = 1'b0;
      zd = z_out_data;
      chk("z_occ1",     32'(z_occupancy), 32'h1);
      chk("z_ctrl1",    32'(z_out_ctrl),  32'h61);
      chk("z_data1",    zd[31:0],         32'h5A61_5A61);
      chk("z_ready_bp", 32'(z_in_ready),  32'h0);
      z_out_ready = 1'b1;
      #1;
      chk("z_ready_comb", 32'(z_in_ready), 32'h1);
      z_stall = 1'b1;
      #1;
      chk("z_ready_stall", 32'(z_in_ready), 32'h0);
      z_stall = 1'b0;
      z_in_valid = 1'b1; z_in_ctrl = 16'h0062; z_in_data = pat(16'h0062);
      @(posedge clk); #1;
      z_in_valid = 1'b0;
      chk("z_replace_ctrl", 32'(z_out_ctrl),  32'h62);
      chk("z_replace_occ",  32'(z_occupancy), 32'h1);
      @(posedge clk); #1;
      chk("z_empty_valid", 32'(z_out_valid), 32'h0);
      chk("z_empty_ctrl",  32'(z_out_ctrl),  32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pipe_stage_reg
